vga_pattern_sequencer: RTL

- Frame-synchronous controller that decides which pattern the VGA pattern generator draws and supplies its animation phase.
- Sits between the board inputs (push-button, mode switches on `ui_in`) and the pattern datapath inside `tt_um_lukasdragoste_vga_patterns`.
- Driven by the one-cycle frame-start pulse from the VGA timing generator.
- Supports manual stepping, timed auto-cycling, pseudo-random selection and freeze.

---
 rtl/vga_pattern_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern selector for the VGA pattern generator: debounced
// button stepping, timed auto-cycling, LFSR-driven random choice and freeze.
module vga_pattern_sequencer #(
    parameter int PAT_W        = 3,
    parameter int DWELL_FRAMES = 120
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             frame_start,
    input  logic             btn_next,
    input  logic [1:0]       mode,
    output logic [PAT_W-1:0] pattern_sel,
    output logic [7:0]       phase,
    output logic             pattern_change
);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_HOLD   = 2'b10,
        ST_RANDOM = 2'b11
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       dwell_cnt;
    logic [7:0]       dwell_eff;
    logic [7:0]       lfsr;
    logic             sync_p0;
    logic             sync_p1;
    logic             db;
    logic [1:0]       db_cnt;
    logic             btn_differs;
    logic             db_flip;
    logic             press;
    logic             expiry;
    logic             trigger;

    function automatic state_t decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return ST_MANUAL;
            2'b01:   return ST_AUTO;
            2'b10:   return ST_HOLD;
            default: return ST_RANDOM;
        endcase
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // A random trigger must always land on a different pattern.
    function automatic logic [PAT_W-1:0] pick_random(input logic [7:0] s,
                                                     input logic [PAT_W-1:0] cur);
        logic [PAT_W-1:0] cand;
        cand = s[PAT_W-1:0];
        if (cand == cur)
            cand = cand + PAT_W'(1);
        return cand;
    endfunction

    always_comb begin
        state_nxt   = decode_mode(mode);
        dwell_eff   = (state_nxt != state) ? 8'd0 : dwell_cnt;
        btn_differs = (sync_p1 != db);
        db_flip     = btn_differs && (db_cnt == 2'd2);
        press       = db_flip && !db;
        expiry      = (dwell_eff == DWELL_LAST);
        trigger     = press || expiry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_MANUAL;
            dwell_cnt      <= 8'd0;
            lfsr           <= LFSR_SEED;
            sync_p0        <= 1'b0;
            sync_p1        <= 1'b0;
            db             <= 1'b0;
            db_cnt         <= 2'd0;
            pattern_sel    <= '0;
            phase          <= 8'd0;
            pattern_change <= 1'b0;
        end else if (ena) begin
            sync_p0        <= btn_next;
            sync_p1        <= sync_p0;
            pattern_change <= 1'b0;
            if (frame_start) begin
                if (!btn_differs) begin
                    db_cnt <= 2'd0;
                end else if (db_flip) begin
                    db     <= ~db;
                    db_cnt <= 2'd0;
                end else begin
                    db_cnt <= db_cnt + 2'd1;
                end

                lfsr  <= lfsr_step(lfsr);
                state <= state_nxt;
                if (state_nxt != ST_HOLD)
                    phase <= phase + 8'd1;

                case (state_nxt)
                    ST_MANUAL: begin
                        dwell_cnt <= 8'd0;
                        if (press) begin
                            pattern_sel    <= pattern_sel + PAT_W'(1);
                            pattern_change <= 1'b1;
                        end
                    end
                    ST_AUTO: begin
                        if (trigger) begin
                            pattern_sel    <= pattern_sel + PAT_W'(1);
                            pattern_change <= 1'b1;
                            dwell_cnt      <= 8'd0;
                        end else begin
                            dwell_cnt <= dwell_eff + 8'd1;
                        end
                    end
                    ST_RANDOM: begin
                        if (trigger) begin
                            pattern_sel    <= pick_random(lfsr, pattern_sel);
                            pattern_change <= 1'b1;
                            dwell_cnt      <= 8'd0;
                        end else begin
                            dwell_cnt <= dwell_eff + 8'd1;
                        end
                    end
                    default: begin
                        dwell_cnt <= dwell_eff;
                    end
                endcase
            end
        end
    end

endmodule
